// File: rtl/time_set_controller.sv
// Mode/time-set sequencer for the clock counter chain: key debounce, RUN/SET FSM,
// inc/clear pulses with auto-repeat, and edit-field blink masks. Optional: SET_TIMEOUT_EN.

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ARM_N = DEBOUNCE_CYCLES + 2;
  localparam int AW    = $clog2(ARM_N + 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_N);

  logic          s1_q, s2_q, deb_q, deb_d, press_q, press_d, armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] arm_q, arm_d;

  // A key held through reset stays disarmed until it has been seen released.
  always_comb begin
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    arm_d   = arm_q;
    armed_d = armed_q;
    if (s2_q == deb_q) cnt_d = '0;
    else if (cnt_q == DB_LAST) begin
      deb_d = s2_q;
      cnt_d = '0;
    end else cnt_d = cnt_q + CW'(1);
    if (!s2_q) arm_d = '0;
    else if (arm_q != ARM_LAST) arm_d = arm_q + AW'(1);
    if (arm_q == ARM_LAST) armed_d = 1'b1;
    press_d = armed_q & deb_q & ~deb_d;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      deb_q   <= 1'b1;
      press_q <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      arm_q   <= '0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
    end
  end

  assign level_o = deb_q;
  assign press_o = press_q;
endmodule

module time_set_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_HALF      = 12500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int TIMEOUT_TICKS   = 30
) (
  input  logic       clockIn,
  input  logic       reset,
  input  logic       modeBtn,
  input  logic       incBtn,
  input  logic       secTick,
  output logic       runEn,
  output logic       incHour,
  output logic       incMin,
  output logic       clrSec,
  output logic [5:0] blankMask,
  output logic [1:0] mode
);
  typedef enum logic [1:0] {S_RUN = 2'b00, S_HOUR = 2'b01, S_MIN = 2'b10, S_SEC = 2'b11} state_t;

  localparam int KEY_MODE = 0;
  localparam int KEY_INC  = 1;
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [1:0] keys_raw, key_lvl, key_press;
  assign keys_raw = {incBtn, modeBtn};

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .gclk    (clockIn),
      .grst_n  (reset),
      .btn_i   (keys_raw[k]),
      .level_o (key_lvl[k]),
      .press_o (key_press[k])
    );
  end

  wire unused_mode_lvl = key_lvl[KEY_MODE];

  logic mode_press, inc_press, inc_rel;
  assign mode_press = key_press[KEY_MODE];
  assign inc_press  = key_press[KEY_INC];
  assign inc_rel    = key_lvl[KEY_INC];

  state_t state_q, state_d;
  logic   state_chg, inc_evt, edit_hm, fire, to_hit;

  logic          rep_act_q, rep_act_d, rep_run_q, rep_run_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [BW-1:0] bl_cnt_q, bl_cnt_d;
  logic          phase_q, phase_d;
  logic          runEn_q, runEn_d, incHour_q, incHour_d, incMin_q, incMin_d, clrSec_q, clrSec_d;
  logic [5:0]    blank_q, blank_d;

`ifdef SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_TICKS);
  logic [TW-1:0] to_q, to_d;

  assign to_hit = (state_q != S_RUN) && (to_q == TO_MAX);

  always_comb begin
    to_d = to_q;
    if (state_q == S_RUN || state_chg || mode_press || inc_press || fire) to_d = '0;
    else if (secTick && to_q != TO_MAX) to_d = to_q + TW'(1);
  end

  always_ff @(posedge clockIn or negedge reset) begin
    if (!reset) to_q <= '0;
    else        to_q <= to_d;
  end
`else
  wire unused_sectick = secTick;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      case (state_q)
        S_RUN:   state_d = S_HOUR;
        S_HOUR:  state_d = S_MIN;
        S_MIN:   state_d = S_SEC;
        default: state_d = S_RUN;
      endcase
    end
    if (to_hit) state_d = S_RUN;
  end

  // Any state change swallows a coincident inc press rather than queueing it.
  assign state_chg = (state_d != state_q);
  assign inc_evt   = inc_press & ~state_chg;
  assign edit_hm   = (state_q == S_HOUR) || (state_q == S_MIN);

  always_comb begin
    rep_act_d = rep_act_q;
    rep_run_d = rep_run_q;
    rep_cnt_d = rep_cnt_q;
    fire      = 1'b0;
    if (state_chg || inc_rel) begin
      rep_act_d = 1'b0;
      rep_run_d = 1'b0;
      rep_cnt_d = '0;
    end else if (inc_evt && edit_hm) begin
      rep_act_d = 1'b1;
      rep_run_d = 1'b0;
      rep_cnt_d = '0;
    end else if (rep_act_q) begin
      if (rep_cnt_q == (rep_run_q ? RP_LAST : RD_LAST)) begin
        fire      = 1'b1;
        rep_run_d = 1'b1;
        rep_cnt_d = '0;
      end else rep_cnt_d = rep_cnt_q + RW'(1);
    end
  end

  // Blink restarts on every state entry so the edited field shows first.
  always_comb begin
    bl_cnt_d = bl_cnt_q;
    phase_d  = phase_q;
    if (state_chg) begin
      bl_cnt_d = '0;
      phase_d  = 1'b0;
    end else if (bl_cnt_q == BL_LAST) begin
      bl_cnt_d = '0;
      phase_d  = ~phase_q;
    end else bl_cnt_d = bl_cnt_q + BW'(1);

    blank_d = 6'b000000;
    if (phase_d) begin
      case (state_d)
        S_HOUR:  blank_d = 6'b110000;
        S_MIN:   blank_d = 6'b001100;
        S_SEC:   blank_d = 6'b000011;
        default: blank_d = 6'b000000;
      endcase
    end

    runEn_d   = (state_d == S_RUN);
    incHour_d = (state_q == S_HOUR) & ((inc_evt & edit_hm) | fire);
    incMin_d  = (state_q == S_MIN) & ((inc_evt & edit_hm) | fire);
    clrSec_d  = (state_q == S_SEC) & inc_evt;
  end

  always_ff @(posedge clockIn or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RUN;
      rep_act_q <= 1'b0;
      rep_run_q <= 1'b0;
      rep_cnt_q <= '0;
      bl_cnt_q  <= '0;
      phase_q   <= 1'b0;
      runEn_q   <= 1'b1;
      incHour_q <= 1'b0;
      incMin_q  <= 1'b0;
      clrSec_q  <= 1'b0;
      blank_q   <= 6'b000000;
    end else begin
      state_q   <= state_d;
      rep_act_q <= rep_act_d;
      rep_run_q <= rep_run_d;
      rep_cnt_q <= rep_cnt_d;
      bl_cnt_q  <= bl_cnt_d;
      phase_q   <= phase_d;
      runEn_q   <= runEn_d;
      incHour_q <= incHour_d;
      incMin_q  <= incMin_d;
      clrSec_q  <= clrSec_d;
      blank_q   <= blank_d;
    end
  end

  assign mode      = state_q;
  assign runEn     = runEn_q;
  assign incHour   = incHour_q;
  assign incMin    = incMin_q;
  assign clrSec    = clrSec_q;
  assign blankMask = blank_q;
endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with short timing parameters.

module tb_time_set_controller;
  logic       clockIn = 1'b0;
  logic       reset   = 1'b0;
  logic       modeBtn = 1'b1;
  logic       incBtn  = 1'b1;
  logic       secTick = 1'b0;
  logic       runEn, incHour, incMin, clrSec;
  logic [5:0] blankMask;
  logic [1:0] mode;

  int errors = 0;
  int checks = 0;

  time_set_controller #(
    .DEBOUNCE_CYCLES(4), .BLINK_HALF(8), .REPEAT_DELAY(16), .REPEAT_PERIOD(4), .TIMEOUT_TICKS(3)
  ) dut (
    .clockIn(clockIn), .reset(reset), .modeBtn(modeBtn), .incBtn(incBtn), .secTick(secTick),
    .runEn(runEn), .incHour(incHour), .incMin(incMin), .clrSec(clrSec),
    .blankMask(blankMask), .mode(mode)
  );

  always #5 clockIn = ~clockIn;

  int cyc = 0, n_hour = 0, n_min = 0, n_clr = 0;
  int t_min [0:63];

  always @(negedge clockIn) begin
    cyc <= cyc + 1;
    if (incHour) n_hour <= n_hour + 1;
    if (clrSec)  n_clr  <= n_clr + 1;
    if (incMin) begin
      if (n_min < 64) t_min[n_min] <= cyc;
      n_min <= n_min + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clockIn);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_mode();
    modeBtn = 1'b0; tick(12);
    modeBtn = 1'b1; tick(12);
  endtask

  task automatic press_inc(input int hold);
    incBtn = 1'b0; tick(hold);
    incBtn = 1'b1; tick(30);
  endtask

  task automatic enter_by_mode(input logic [1:0] target, input string tag);
    int k;
    modeBtn = 1'b0;
    k = 0;
    while (k < 50 && mode !== target) begin
      tick(1);
      k++;
    end
    chk(tag, mode, target);
    modeBtn = 1'b1;
  endtask

  initial begin
    int bad, bh, bm, bc, b0;
    logic [5:0] exp_mask;
    logic [1:0] exp_pre;

    // reset state, asserted and after release with no keys
    tick(3);
    chk("rst_mode", mode, 2'b00);
    chk("rst_runEn", runEn, 1'b1);
    chk("rst_mask", blankMask, 6'b000000);
    chk("rst_pulses", {incHour, incMin, clrSec}, 3'b000);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (mode !== 2'b00 || runEn !== 1'b1 || blankMask !== 6'b0 || {incHour, incMin, clrSec} !== 3'b0)
        bad++;
    end
    chk("idle_bad_cycles", bad, 0);

    // short glitch is filtered, then four clean mode presses
    modeBtn = 1'b0; tick(2); modeBtn = 1'b1; tick(20);
    chk("glitch_mode", mode, 2'b00);
    press_mode(); chk("m1_mode", mode, 2'b01); chk("m1_runEn", runEn, 1'b0);
    press_mode(); chk("m2_mode", mode, 2'b10); chk("m2_runEn", runEn, 1'b0);
    press_mode(); chk("m3_mode", mode, 2'b11); chk("m3_runEn", runEn, 1'b0);
    press_mode(); chk("m4_mode", mode, 2'b00); chk("m4_runEn", runEn, 1'b1);

    // blink pattern in SET_HOUR from the entry cycle
    enter_by_mode(2'b01, "enter_hour");
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      exp_mask = ((i / 8) % 2 == 1) ? 6'b110000 : 6'b000000;
      if (blankMask !== exp_mask) bad++;
      if (i == 0) chk("hour_blink_first", blankMask, 6'b000000);
      if (i == 8) chk("hour_blink_ninth", blankMask, 6'b110000);
      tick(1);
    end
    chk("hour_blink_bad", bad, 0);

    // entering SET_MIN restarts the blink visible
    enter_by_mode(2'b10, "enter_min");
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      exp_mask = (i == 8) ? 6'b001100 : 6'b000000;
      if (blankMask !== exp_mask) bad++;
      tick(1);
    end
    chk("min_blink_bad", bad, 0);
    tick(20);

    // held inc in SET_MIN: press pulse, repeat after 16, then every 4
    bh = n_hour; bm = n_min; bc = n_clr;
    press_inc(34);
    chk("hold_min_count", n_min - bm, 6);
    chk("hold_hour_none", n_hour - bh, 0);
    chk("hold_clr_none", n_clr - bc, 0);
    chk("repeat_delay", t_min[bm + 1] - t_min[bm], 16);
    chk("repeat_period", t_min[bm + 2] - t_min[bm + 1], 4);
    bm = n_min; tick(30);
    chk("after_release", n_min - bm, 0);

    // SET_SEC: one clear per press, no repeat
    press_mode(); chk("sec_mode", mode, 2'b11);
    bh = n_hour; bm = n_min; bc = n_clr;
    press_inc(40);
    chk("sec_clr_once", n_clr - bc, 1);
    chk("sec_no_inc", (n_hour - bh) + (n_min - bm), 0);

    // RUN ignores inc
    press_mode(); chk("run_mode", mode, 2'b00);
    b0 = n_hour + n_min + n_clr;
    press_inc(40);
    chk("run_no_pulse", n_hour + n_min + n_clr - b0, 0);

    // simultaneous mode+inc in SET_HOUR: mode wins, inc dropped
    press_mode(); chk("simul_pre", mode, 2'b01);
    bh = n_hour; bm = n_min;
    modeBtn = 1'b0; incBtn = 1'b0; tick(12);
    modeBtn = 1'b1; incBtn = 1'b1; tick(30);
    chk("simul_mode", mode, 2'b10);
    chk("simul_no_hour", n_hour - bh, 0);
    chk("simul_no_min", n_min - bm, 0);

    // secTick timeout in SET_MIN
    for (int i = 0; i < 3; i++) begin
      secTick = 1'b1; tick(1); secTick = 1'b0; tick(5);
    end
`ifdef SET_TIMEOUT_EN
    chk("timeout_mode", mode, 2'b00);
    chk("timeout_runEn", runEn, 1'b1);
    chk("timeout_mask", blankMask, 6'b000000);
    exp_pre = 2'b01;
`else
    for (int i = 0; i < 10; i++) begin
      secTick = 1'b1; tick(1); secTick = 1'b0; tick(5);
    end
    chk("no_timeout_mode", mode, 2'b10);
    chk("no_timeout_runEn", runEn, 1'b0);
    exp_pre = 2'b11;
`endif

    // reset mid-edit with mode key held: async return, re-press required
    press_mode(); chk("pre_reset_mode", mode, exp_pre);
    modeBtn = 1'b0; tick(10);
    reset = 1'b0; #1;
    chk("async_rst_mode", mode, 2'b00);
    chk("async_rst_runEn", runEn, 1'b1);
    chk("async_rst_mask", blankMask, 6'b000000);
    tick(3); reset = 1'b1; tick(40);
    chk("held_through_reset", mode, 2'b00);
    modeBtn = 1'b1; tick(20);
    press_mode(); chk("repress_mode", mode, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
